// File: rtl/prng_pkg.sv
// Shared types and constants for the seeded 8-bit PRNG.
package prng_pkg;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    IDLE     = 2'd1,
    GEN      = 2'd2
  } prng_state_e;

  // Tap masks: the feedback bit is the XOR of the state bits selected by the mask.
  // POLY0 = x^8+x^6+x^5+x^4+1, POLY1 = x^8+x^4+x^3+x^2+1
  localparam logic [7:0] POLY0         = 8'hB8;
  localparam logic [7:0] POLY1         = 8'h8E;
  localparam int         STEPS         = 8;
  localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

  // One Fibonacci step: shift left, feed the parity of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic sel);
    logic [7:0] mask;
    mask = sel ? POLY1 : POLY0;
    return {s[6:0], ^(s & mask)};
  endfunction

endpackage

// File: rtl/prng_lfsr8.sv
// 8-bit LFSR state register with synchronous load and single-step advance.
module prng_lfsr8
  import prng_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  input  logic       sel,
  output logic [7:0] state
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  // Next state: a load wins over a step; otherwise hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = lfsr_next(state_q, sel);
    end
  end

  // State register, cleared to 0x00 until a seed is loaded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/my_chip_prng.sv
// Chip-level PRNG wrapper: seed load, 8-step generation per request, padframe bus packing.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// UNSEEDED | after reset; en loads seed (0x00 replaced by 0x01)
// IDLE     | seeded, waiting; en latches sel and starts a generation
// GEN      | LFSR advances once per cycle; 8th step publishes the byte
module my_chip_prng
  import prng_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  logic [7:0] seed;
  logic       sel;
  logic       en;
  logic       unused_io;

  assign seed      = io_in[9:2];
  assign sel       = io_in[1];
  assign en        = io_in[0];
  assign unused_io = ^io_in[11:10];

  prng_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic [7:0]  rand_q, rand_d;
  logic        valid_q, valid_d;

  logic        lfsr_load;
  logic        lfsr_step;
  logic [7:0]  lfsr_state;
  logic [7:0]  lfsr_nxt;
  logic [7:0]  seed_val;

  // An all-zero seed would lock the LFSR, so substitute a non-zero one.
  assign seed_val = (seed == 8'h00) ? SEED_ZERO_SUB : seed;
  // Value the LFSR takes on this step; published directly on the 8th step.
  assign lfsr_nxt = lfsr_next(lfsr_state, sel_q);

  prng_lfsr8 u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .load     (lfsr_load),
    .load_val (seed_val),
    .step     (lfsr_step),
    .sel      (sel_q),
    .state    (lfsr_state)
  );

  // FSM next-state, step counter and output register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    rand_d    = rand_q;
    valid_d   = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      UNSEEDED: begin
        if (en) begin
          lfsr_load = 1'b1;
          state_d   = IDLE;
        end
      end
      IDLE: begin
        if (en) begin
          sel_d   = sel;
          cnt_d   = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        lfsr_step = 1'b1;
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == LAST_STEP) begin
          rand_d  = lfsr_nxt;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = UNSEEDED;
      end
    endcase
  end

  // Control and output registers; reset aborts any generation in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= UNSEEDED;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      rand_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
    end
  end

  assign io_out = {3'b000, valid_q, rand_q};

endmodule

// File: tb/tb_my_chip_prng.sv
// Directed self-checking bench for my_chip_prng.
module tb_my_chip_prng;

  logic        clock;
  logic        reset;
  logic [11:0] io_in;
  logic [11:0] io_out;

  int checks = 0;
  int errors = 0;

  my_chip_prng dut (
    .clock  (clock),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: eight Fibonacci steps with the taps written out bit by bit.
  function automatic logic [7:0] model8(input logic [7:0] s0, input logic sel);
    logic [7:0] s;
    logic       fb;
    s = s0;
    for (int k = 0; k < 8; k++) begin
      if (sel) fb = s[7] ^ s[3] ^ s[2] ^ s[1];
      else     fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      s = {s[6:0], fb};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    io_in = 12'h000;
    reset = 1'b0;
    cycle();
    cycle();
    check("reset_out", io_out, 12'h000);
    reset = 1'b1;
    cycle();
  endtask

  task automatic load_seed(input logic [7:0] seed);
    io_in = {2'b00, seed, 1'b0, 1'b1};
    cycle();
    io_in = 12'h000;
  endtask

  // One request: accept, no valid for 7 cycles, valid+byte at N+8, valid low at N+9.
  task automatic request(input string tag, input logic sel, input logic [7:0] exp);
    logic seen;
    io_in = {2'b00, 8'h00, sel, 1'b1};
    cycle();
    io_in = 12'h000;
    seen = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (io_out[8]) seen = 1'b1;
    end
    check({tag, "_early_valid"}, {11'd0, seen}, 12'h000);
    cycle();
    check({tag, "_n8"}, io_out, {3'b000, 1'b1, exp});
    cycle();
    check({tag, "_n9"}, io_out, {3'b000, 1'b0, exp});
  endtask

  initial begin
    logic [7:0] exp_v;
    logic       seen;
    int         pulses;

    reset = 1'b0;
    io_in = 12'h000;

    // 1: seed 0xCC, sel=0 -> 0x5A; seed load alone must not disturb outputs
    apply_reset();
    load_seed(8'hCC);
    check("seed_no_out_0", io_out, 12'h000);
    cycle();
    check("seed_no_out_1", io_out, 12'h000);
    request("sel0_cc", 1'b0, 8'h5A);

    // 2: seed 0xCC, sel=1 -> 0xBF; then switch to sel=0 continuing from 0xBF
    apply_reset();
    load_seed(8'hCC);
    cycle();
    request("sel1_cc", 1'b1, 8'hBF);
    exp_v = model8(8'hBF, 1'b0);
    request("sel_switch", 1'b0, exp_v);

    // 3: 50 requests every 101 cycles from seed 0xCC
    apply_reset();
    load_seed(8'hCC);
    cycle();
    exp_v  = 8'hCC;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      io_in = 12'h001;
      cycle();
      io_in = 12'h000;
      for (int k = 0; k < 100; k++) begin
        cycle();
        if (io_out[8]) begin
          pulses++;
          exp_v = model8(exp_v, 1'b0);
          check("stream_val", {4'h0, io_out[7:0]}, {4'h0, exp_v});
          check("stream_nonzero", {11'd0, (io_out[7:0] == 8'h00)}, 12'h000);
        end
      end
    end
    check("stream_count", 12'(pulses), 12'd50);

    // 4: zero seed substituted by 0x01 -> 0x1C after 8 steps
    apply_reset();
    load_seed(8'h00);
    cycle();
    request("zero_seed", 1'b0, 8'h1C);

    // 5: en re-pulse with new seed/sel during GEN is ignored
    apply_reset();
    load_seed(8'hCC);
    cycle();
    io_in = 12'h001;
    cycle();
    io_in = 12'h000;
    cycle();
    cycle();
    io_in = {2'b00, 8'h55, 1'b1, 1'b1};
    cycle();
    io_in = 12'h000;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (io_out[8]) seen = 1'b1;
    end
    check("repulse_early", {11'd0, seen}, 12'h000);
    cycle();
    check("repulse_n8", io_out, {4'b0001, 8'h5A});
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (io_out[8]) pulses++;
    end
    check("repulse_single", 12'(pulses), 12'd0);
    exp_v = model8(8'h5A, 1'b0);
    request("repulse_next", 1'b0, exp_v);

    // 6: reset mid-GEN aborts; new seed load yields no output
    apply_reset();
    load_seed(8'hCC);
    cycle();
    io_in = 12'h001;
    cycle();
    io_in = 12'h000;
    for (int k = 0; k < 4; k++) cycle();
    reset = 1'b0;
    #1;
    check("abort_out_now", io_out, 12'h000);
    io_in = 12'h001;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (io_out != 12'h000) seen = 1'b1;
    end
    io_in = 12'h000;
    reset = 1'b1;
    load_seed(8'h33);
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (io_out != 12'h000) seen = 1'b1;
    end
    check("abort_quiet", {11'd0, seen}, 12'h000);
    exp_v = model8(8'h33, 1'b0);
    request("abort_reseed", 1'b0, exp_v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_chip_prng.md
# my_chip_prng

Seeded 8-bit pseudo-random number generator in a chip-level wrapper. The block sits directly on the padframe's 12-bit input and output buses. A first request after reset loads a user seed. Each later request runs the selected 8-bit LFSR for eight steps and presents a fresh byte with a one-cycle `valid` strobe.

## Interface
Parameters: none; all widths are fixed.

Clock and reset: one clock; reset is asynchronous and active-low. The ports are named `clock` and `reset`, as elsewhere in the codebase.

Ports:
- `clock`  in  1  — rising-edge system clock.
- `reset`  in  1  — asynchronous, active-low; `0` clears all state.
- `io_in`  in  12 — input bus:
  - `[9:2]` = `seed`
  - `[1]` = `sel` (LFSR select)
  - `[0]` = `en` (request)
  - `[11:10]` are unused.
- `io_out`  out  12 — output bus:
  - `[8]` = `valid`
  - `[7:0]` = `rand_num`
  - `[11:9]` are tied to `0`.

## Operation
- States: `UNSEEDED`, `IDLE`, `GEN`.
  - `UNSEEDED` is the reset state.
- `UNSEEDED` with `en=1`:
  - state register ← `seed`; a seed of `0x00` is replaced by `0x01` to avoid LFSR lockup.
  - next state is `IDLE`.
  - No output change and no `valid`.
- `IDLE` with `en=1`:
  - latch `sel` into `sel_q`.
  - clear the step counter; next state is `GEN`.
- `GEN`: advance the LFSR once per cycle for 8 cycles, using the polynomial chosen by `sel_q`.
  - After the 8th step: `rand_num` ← new state, `valid` ← 1 for one cycle, next state is `IDLE`.
- LFSR stepping (Fibonacci form): `s ← {s[6:0], fb}`.
  - `sel_q=0`: x^8+x^6+x^5+x^4+1, with `fb = s[7]^s[5]^s[4]^s[3]`.
  - `sel_q=1`: x^8+x^4+x^3+x^2+1, with `fb = s[7]^s[3]^s[2]^s[1]`.
  - Both polynomials are primitive, giving period 255. The state is never `0x00`.
- The state carries across requests: each result seeds the next. Switching `sel` between requests continues from the current state.
- `en` during `GEN` is ignored; no queuing.
- `sel` changes during `GEN` are ignored.
- `seed` is ignored outside `UNSEEDED`. Re-seeding requires reset.
- `en` is level-sampled. Holding it high in `IDLE` starts a new generation on each return to `IDLE`, i.e. back-to-back bytes every 9 cycles.
- `rand_num` holds its last value until the next completion.

## Timing
- Reset values:
  - `rand_num = 0x00`, `valid = 0`, state register `0x00`.
  - FSM in `UNSEEDED`, counter `0`, `io_out[11:9] = 0`.
- All outputs are registered; there is no combinational path from `io_in` to `io_out`.
- Seed load: takes effect at the edge sampling `en=1`; the FSM is in `IDLE` on the next cycle.
- Request accepted at edge N (in `IDLE`):
  - LFSR steps at edges N+1 … N+8.
  - `rand_num` updates and `valid` rises at edge N+8.
  - `valid` falls at edge N+9.
  - The earliest next acceptance is edge N+9.
- Reset asserted mid-`GEN`: the generation is aborted immediately with no `valid`. All values return to reset state, and a new seed is required.

## Structure
- Package `prng_pkg`:
  - FSM state enum (`UNSEEDED`, `IDLE`, `GEN`).
  - Tap-mask constants `POLY0 = 8'hB8` and `POLY1 = 8'h8E`; `fb` is the XOR-reduction of `s & mask`.
  - `STEPS = 8`.
  - `SEED_ZERO_SUB = 8'h01`.
- Sub-module `prng_lfsr8`:
  - Holds the 8-bit state register.
  - Inputs: `load`, `load_val`, `step`, `sel`.
  - Output: the current state.
- The top level contains the FSM, the 3-bit step counter, the output registers and the bus packing.

## Test plan
- Reset, then `seed=0xCC`, `sel=0`, `en` pulse, then a further `en` pulse → `valid` high one cycle, 8 cycles after acceptance, with `rand_num=0x5A`.
- Same flow with `sel=1` on the generation pulse → `rand_num=0xBF`.
- `en` pulsed every 101 cycles, 50 times, with `sel=0` from seed `0xCC` → exactly 50 `valid` pulses. Each value is the 8-step successor of the previous one, checked against a reference model, and no value is `0x00`.
- `seed=0x00` load, then one request with `sel=0` → no lockup: the state starts from `0x01` and `rand_num` is non-zero.
- `en` re-pulsed at acceptance+3 and `seed` changed → ignored: a single `valid` and an unchanged sequence.
- Reset asserted at acceptance+4 → `valid` never asserts. Outputs read `0x000` immediately. A fresh `en` reloads the seed and produces no output.
